// File: rtl/ball_step_scheduler_pkg.sv
// Shared types for the ball step scheduler: scheduler states, accelerometer
// sample type and a saturating counter helper.
package ball_pkg;

  localparam int ACCEL_W = 8;

  typedef logic signed [ACCEL_W-1:0] accel_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_SAMPLE = 2'd1,
    WAIT_FRAME  = 2'd2,
    STEP        = 2'd3
  } sched_state_t;

  // Overrun events can coincide (timeout and missed tick), so add up to 3.
  function automatic logic [7:0] sat_add_u8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/ball_step_scheduler_if.sv
// Accelerometer sample handshake: one signed sample per axis, accepted when
// valid and ready are both high on a clock edge.
interface ball_step_scheduler_if;
  import ball_pkg::*;

  logic   valid;
  logic   ready;
  accel_t x;
  accel_t y;

  modport master (output valid, output x, output y, input ready);
  modport slave  (input valid, input x, input y, output ready);

endinterface

// File: rtl/ball_step_scheduler_accel_dead_zone.sv
// Combinational dead-zone for one accelerometer axis: small readings are
// forced to zero so sensor noise does not make the ball drift.
module accel_dead_zone
  import ball_pkg::*;
#(
  parameter int DEAD_ZONE = 4
) (
  input  accel_t raw,
  output accel_t zoned
);

  localparam int WIDE_W = ACCEL_W + 1;
  localparam logic [WIDE_W-1:0] LIMIT = WIDE_W'(DEAD_ZONE);

  logic signed [WIDE_W-1:0] wide;
  logic        [WIDE_W-1:0] mag;

  // One extra bit so the magnitude of -128 is representable.
  always_comb begin
    wide  = {raw[ACCEL_W-1], raw};
    mag   = wide[WIDE_W-1] ? $unsigned(-wide) : $unsigned(wide);
    zoned = (mag < LIMIT) ? '0 : raw;
  end

endmodule

// File: rtl/ball_step_scheduler.sv
// Paces ball physics: one accelerometer sample per step period, then a single
// step strobe on the next frame start so the ball only moves during blanking.
module ball_step_scheduler
  import ball_pkg::*;
#(
  parameter int STEP_PERIOD    = 1048576,
  parameter int SAMPLE_TIMEOUT = 4096,
  parameter int DEAD_ZONE      = 4
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        i_enable,
  input  logic                        i_recentre,
  input  logic                        i_frame_start,
  ball_step_scheduler_if.slave        accel,
  output logic                        o_step,
  output logic                        o_recentre,
  output accel_t                      o_accel_x,
  output accel_t                      o_accel_y,
  output logic [1:0]                  o_state,
  output logic [7:0]                  o_overrun_cnt
);

  localparam int PERIOD_W  = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int TIMEOUT_W = (SAMPLE_TIMEOUT > 1) ? $clog2(SAMPLE_TIMEOUT) : 1;
  localparam logic [PERIOD_W-1:0]  PERIOD_LAST  = PERIOD_W'(STEP_PERIOD - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(SAMPLE_TIMEOUT - 1);

  sched_state_t         state_reg, state_next;
  logic [PERIOD_W-1:0]  period_reg, period_next;
  logic [TIMEOUT_W-1:0] timeout_reg, timeout_next;
  logic                 pending_reg, pending_next;
  logic                 step_reg, step_next;
  logic                 recentre_reg, recentre_next;
  accel_t               accel_x_reg, accel_x_next;
  accel_t               accel_y_reg, accel_y_next;
  logic [7:0]           overrun_reg, overrun_next;

  logic       tick;
  logic       accept;
  logic       timeout;
  logic [1:0] overrun_inc;

  accel_t raw [2];
  accel_t zoned [2];

  assign raw[0] = accel.x;
  assign raw[1] = accel.y;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      accel_dead_zone #(.DEAD_ZONE(DEAD_ZONE)) u_dead_zone (
        .raw   (raw[gi]),
        .zoned (zoned[gi])
      );
    end
  endgenerate

  // Ready is a pure state decode, so it never depends on valid combinationally.
  assign accel.ready   = (state_reg == WAIT_SAMPLE);
  assign o_step        = step_reg;
  assign o_recentre    = recentre_reg;
  assign o_accel_x     = accel_x_reg;
  assign o_accel_y     = accel_y_reg;
  assign o_state       = state_reg;
  assign o_overrun_cnt = overrun_reg;

  always_comb begin
    tick          = (period_reg == PERIOD_LAST);
    accept        = (state_reg == WAIT_SAMPLE) && accel.valid;
    timeout       = (state_reg == WAIT_SAMPLE) && !accel.valid && (timeout_reg == TIMEOUT_LAST);
    state_next    = state_reg;
    period_next   = period_reg;
    timeout_next  = '0;
    pending_next  = pending_reg;
    step_next     = 1'b0;
    recentre_next = 1'b0;
    accel_x_next  = accel_x_reg;
    accel_y_next  = accel_y_reg;
    overrun_inc   = 2'd0;

    if (!i_enable) begin
      state_next   = IDLE;
      period_next  = '0;
      pending_next = 1'b0;
    end else if (i_recentre) begin
      // Recentre overrides any same-cycle accept or step; the sample is dropped.
      state_next    = WAIT_SAMPLE;
      recentre_next = 1'b1;
      accel_x_next  = '0;
      accel_y_next  = '0;
      period_next   = '0;
      pending_next  = 1'b1;
    end else begin
      period_next = (state_reg == IDLE || tick) ? '0 : period_reg + PERIOD_W'(1);
      if (tick) begin
        if (pending_reg) overrun_inc = overrun_inc + 2'd1;
        pending_next = 1'b1;
      end

      case (state_reg)
        IDLE: state_next = WAIT_SAMPLE;
        WAIT_SAMPLE: begin
          if (accept) begin
            accel_x_next = zoned[0];
            accel_y_next = zoned[1];
            state_next   = WAIT_FRAME;
          end else if (timeout) begin
            overrun_inc = overrun_inc + 2'd1;
            state_next  = WAIT_FRAME;
          end else begin
            timeout_next = timeout_reg + TIMEOUT_W'(1);
          end
        end
        WAIT_FRAME: begin
          if (i_frame_start) begin
            state_next = STEP;
            step_next  = 1'b1;
          end
        end
        STEP: begin
          // Staying here after the strobe is the hold until the next period.
          if (pending_reg || tick) state_next = WAIT_SAMPLE;
        end
        default: state_next = IDLE;
      endcase

      if (state_next == WAIT_SAMPLE && state_reg != WAIT_SAMPLE) pending_next = 1'b0;
    end

    overrun_next = sat_add_u8(overrun_reg, overrun_inc);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= IDLE;
      period_reg   <= '0;
      timeout_reg  <= '0;
      pending_reg  <= 1'b0;
      step_reg     <= 1'b0;
      recentre_reg <= 1'b0;
      accel_x_reg  <= '0;
      accel_y_reg  <= '0;
      overrun_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      period_reg   <= period_next;
      timeout_reg  <= timeout_next;
      pending_reg  <= pending_next;
      step_reg     <= step_next;
      recentre_reg <= recentre_next;
      accel_x_reg  <= accel_x_next;
      accel_y_reg  <= accel_y_next;
      overrun_reg  <= overrun_next;
    end
  end

endmodule

// File: tb/tb_ball_step_scheduler.sv
// Directed bench for ball_step_scheduler with a 16-cycle period, 8-cycle
// sample timeout and dead zone of 4; expected values are worked out by hand.
module tb_ball_step_scheduler;
  import ball_pkg::*;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       enable = 1'b0;
  logic       recentre = 1'b0;
  logic       frame_start = 1'b0;
  logic       step;
  logic       recentre_out;
  accel_t     accel_x;
  accel_t     accel_y;
  logic [1:0] state;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int passes = 0;
  int step_count = 0;
  int step_mark = 0;

  ball_step_scheduler_if accel ();

  ball_step_scheduler #(
    .STEP_PERIOD    (16),
    .SAMPLE_TIMEOUT (8),
    .DEAD_ZONE      (4)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .i_enable      (enable),
    .i_recentre    (recentre),
    .i_frame_start (frame_start),
    .accel         (accel),
    .o_step        (step),
    .o_recentre    (recentre_out),
    .o_accel_x     (accel_x),
    .o_accel_y     (accel_y),
    .o_state       (state),
    .o_overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step) step_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
      $display("pass %s: got %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_sample(input int x, input int y);
    accel.valid = 1'b1;
    accel.x     = 8'(x);
    accel.y     = 8'(y);
  endtask

  initial begin
    accel.valid = 1'b0;
    accel.x     = '0;
    accel.y     = '0;
    cyc(2);
    check_eq("rst_state", state, 0);
    check_eq("rst_ready", accel.ready, 0);
    check_eq("rst_step", step, 0);
    check_eq("rst_overrun", overrun_cnt, 0);

    arst = 1'b0; enable = 1'b1;
    cyc(1);
    check_eq("en_state", state, 1);
    check_eq("en_ready", accel.ready, 1);
    drive_sample(10, -3); frame_start = 1'b1;
    cyc(1);
    check_eq("acc1_state", state, 2);
    check_eq("acc1_x", {accel_x}, 8'h0A);
    check_eq("acc1_y_dz", {accel_y}, 8'h00);
    check_eq("acc1_ready", accel.ready, 0);
    accel.valid = 1'b0; frame_start = 1'b0;
    cyc(1);
    check_eq("frame_ignored_state", state, 2);
    check_eq("frame_ignored_step", step, 0);
    frame_start = 1'b1;
    cyc(1);
    check_eq("step1", step, 1);
    check_eq("step1_state", state, 3);
    check_eq("step1_x", {accel_x}, 8'h0A);
    frame_start = 1'b0;
    cyc(1);
    check_eq("step1_done", step, 0);
    check_eq("hold_state", state, 3);
    cyc(11);
    check_eq("hold_before_tick", state, 3);
    cyc(1);
    check_eq("tick_to_sample", state, 1);

    drive_sample(-128, -4);
    cyc(1);
    check_eq("neg128_x", {accel_x}, 8'h80);
    check_eq("neg4_y", {accel_y}, 8'hFC);
    accel.valid = 1'b0; frame_start = 1'b1;
    cyc(1);
    check_eq("step2", step, 1);
    frame_start = 1'b0;
    cyc(14);
    check_eq("period2_state", state, 1);

    drive_sample(3, 5);
    cyc(1);
    check_eq("pos3_x_dz", {accel_x}, 8'h00);
    check_eq("pos5_y", {accel_y}, 8'h05);
    accel.valid = 1'b0; frame_start = 1'b1;
    cyc(1);
    check_eq("step3", step, 1);
    frame_start = 1'b0;
    cyc(14);
    check_eq("period3_state", state, 1);
    cyc(7);
    check_eq("pre_timeout_state", state, 1);
    check_eq("pre_timeout_overrun", overrun_cnt, 0);
    cyc(1);
    check_eq("timeout_state", state, 2);
    check_eq("timeout_overrun", overrun_cnt, 1);
    frame_start = 1'b1;
    cyc(1);
    check_eq("timeout_step", step, 1);
    check_eq("reuse_x", {accel_x}, 8'h00);
    check_eq("reuse_y", {accel_y}, 8'h05);
    frame_start = 1'b0;
    cyc(7);
    check_eq("period4_state", state, 1);

    drive_sample(20, -20);
    cyc(1);
    check_eq("acc4_x", {accel_x}, 8'h14);
    check_eq("acc4_y", {accel_y}, 8'hEC);
    accel.valid = 1'b0;
    step_mark = step_count;
    cyc(30);
    check_eq("first_miss_overrun", overrun_cnt, 1);
    check_eq("still_wait_frame", state, 2);
    cyc(1);
    check_eq("second_miss_overrun", overrun_cnt, 2);
    cyc(9);
    frame_start = 1'b1;
    cyc(1);
    check_eq("late_step", step, 1);
    check_eq("late_step_overrun", overrun_cnt, 2);
    frame_start = 1'b0;
    cyc(1);
    check_eq("late_step_once", step, 0);
    check_eq("pending_to_sample", state, 1);
    check_eq("late_step_count", step_count - step_mark, 1);

    drive_sample(50, 50);
    cyc(1);
    check_eq("acc5_x", {accel_x}, 8'h32);
    accel.valid = 1'b0; frame_start = 1'b1; recentre = 1'b1;
    cyc(1);
    check_eq("recentre_strobe", recentre_out, 1);
    check_eq("recentre_no_step", step, 0);
    check_eq("recentre_x", {accel_x}, 8'h00);
    check_eq("recentre_y", {accel_y}, 8'h00);
    check_eq("recentre_state", state, 1);
    frame_start = 1'b0; recentre = 1'b0;
    cyc(1);
    check_eq("recentre_done", recentre_out, 0);

    drive_sample(-7, 9);
    cyc(1);
    check_eq("acc6_x", {accel_x}, 8'hF9);
    check_eq("acc6_state", state, 2);
    accel.valid = 1'b0;
    arst = 1'b1;
    #1;
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_x", {accel_x}, 8'h00);
    check_eq("async_rst_y", {accel_y}, 8'h00);
    check_eq("async_rst_overrun", overrun_cnt, 0);
    cyc(1);
    arst = 1'b0;
    check_eq("post_rst_idle", state, 0);
    cyc(1);
    check_eq("resume_state", state, 1);
    enable = 1'b0;
    cyc(1);
    check_eq("disable_state", state, 0);
    check_eq("disable_ready", accel.ready, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
